monitor_bit_fetcher: RTL

Hardware source of `bit_value` for the processor monitor screen. It sits between `vga_sync`/`character_generator` and `instruction_memory`. It decodes the current pixel into a display region, reads the needed word from memory or from a per-frame register snapshot, and delivers the selected bit together with the pixel coordinates, all delayed by a fixed three-cycle pipeline. It is the reading/initiating end of the memory-readout path that feeds `character_generator` and the glyph ROMs.

---
 rtl/monitor_bit_fetcher_if.sv | 16 +
 rtl/monitor_bit_fetcher.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_bit_fetcher_if.sv
// Memory read port between the monitor bit fetcher and the instruction memory.
// The fetcher drives the registered address; memory returns data one cycle later.
interface monitor_bit_fetcher_if;
  logic [10:0] mem_address_out;
  logic [15:0] mem_data_in;

  modport master (
    output mem_address_out,
    input  mem_data_in
  );

  modport slave (
    input  mem_address_out,
    output mem_data_in
  );
endinterface

// File: rtl/monitor_bit_fetcher.sv
// Monitor-screen bit source: decodes each pixel into a display region, fetches the word
// it needs (memory or frame snapshot) and returns the selected bit three cycles later.
module monitor_bit_fetcher #(
  parameter logic [10:0] DATA_BASE = 11'd1
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic [9:0]            pixel_x_in,
  input  logic [9:0]            pixel_y_in,
  input  logic                  display_on_in,
  input  logic                  v_sync_in,
  input  logic [15:0]           pc_in,
  input  logic [15:0]           ir_in,
  input  logic [15:0]           acc_in,
  input  logic [15:0]           data_address_in,
  input  logic [15:0]           alu_a_in,
  input  logic [15:0]           alu_b_in,
  input  logic                  status_z_in,
  monitor_bit_fetcher_if.master mem_bus,
  output logic                  bit_value_out,
  output logic [9:0]            pixel_x_out,
  output logic [9:0]            pixel_y_out,
  output logic                  display_on_out
);

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_VALUE = 2'd1,
    SRC_MEM   = 2'd2
  } src_e;

  logic [15:0] snap_pc_q, snap_ir_q, snap_acc_q, snap_da_q, snap_a_q, snap_b_q;
  logic        snap_z_q;
  logic        vs_q, vs_prev_q;

  logic [6:0]  col_s;
  logic [5:0]  row_s;
  logic        list_left_s, list_right_s, rows_top_s, rows_bot_s;
  logic        box_left_s, box_right_s, z_box_s;
  logic        band_hit_s;
  logic [1:0]  band_s;
  logic [5:0]  top_off_s, bot_off_s;
  logic [10:0] data_addr_s;
  logic [3:0]  list_left_idx_s, list_right_idx_s, box_left_idx_s, box_right_idx_s;
  logic [15:0] left_word_s, right_word_s;
  logic        right_is_mem_s;
  logic [10:0] right_addr_s;

  src_e        src_d, src1_q, src2_q;
  logic [3:0]  idx_d, idx1_q, idx2_q;
  logic [15:0] val_d, val1_q, val2_q;
  logic [10:0] addr_d, addr1_q;
  logic [9:0]  x1_q, y1_q, x2_q, y2_q, x3_q, y3_q;
  logic        de1_q, de2_q, de3_q;
  logic        bit_s, bit3_q;

  assign col_s = pixel_x_in[9:3];
  assign row_s = pixel_y_in[9:4];

  assign list_left_s  = (col_s >= 7'd2)  && (col_s <= 7'd17);
  assign list_right_s = (col_s >= 7'd20) && (col_s <= 7'd35);
  assign rows_top_s   = (row_s >= 6'd3)  && (row_s <= 6'd12);
  assign rows_bot_s   = (row_s >= 6'd19) && (row_s <= 6'd28);
  assign box_left_s   = (pixel_x_in >= 10'd357) && (pixel_x_in <= 10'd484);
  assign box_right_s  = (pixel_x_in >= 10'd503) && (pixel_x_in <= 10'd630);
  assign z_box_s      = (pixel_x_in >= 10'd557) && (pixel_x_in <= 10'd565) &&
                        (pixel_y_in >= 10'd313) && (pixel_y_in <= 10'd328);

  assign top_off_s   = row_s - 6'd3;
  assign bot_off_s   = row_s - 6'd19;
  assign data_addr_s = DATA_BASE + {5'd0, bot_off_s};

  // Bit indices count from the right-hand edge of each field; only the low 4 bits matter.
  assign list_left_idx_s  = 4'(7'd17 - col_s);
  assign list_right_idx_s = 4'(7'd35 - col_s);
  assign box_left_idx_s   = 4'((10'd484 - pixel_x_in) >> 3);
  assign box_right_idx_s  = 4'((10'd630 - pixel_x_in) >> 3);

  always_comb begin
    band_hit_s = 1'b1;
    band_s     = 2'd0;
    if ((pixel_y_in >= 10'd65) && (pixel_y_in <= 10'd80)) begin
      band_s = 2'd0;
    end else if ((pixel_y_in >= 10'd115) && (pixel_y_in <= 10'd130)) begin
      band_s = 2'd1;
    end else if ((pixel_y_in >= 10'd165) && (pixel_y_in <= 10'd180)) begin
      band_s = 2'd2;
    end else if ((pixel_y_in >= 10'd215) && (pixel_y_in <= 10'd230)) begin
      band_s = 2'd3;
    end else begin
      band_hit_s = 1'b0;
    end
  end

  always_comb begin
    left_word_s    = 16'd0;
    right_word_s   = 16'd0;
    right_is_mem_s = 1'b0;
    right_addr_s   = 11'd0;
    case (band_s)
      2'd0: begin
        left_word_s    = snap_pc_q;
        right_is_mem_s = 1'b1;
        right_addr_s   = snap_pc_q[10:0];
      end
      2'd1: begin
        left_word_s    = snap_da_q;
        right_is_mem_s = 1'b1;
        right_addr_s   = snap_da_q[10:0];
      end
      2'd2: begin
        left_word_s  = snap_ir_q;
        right_word_s = snap_acc_q;
      end
      2'd3: begin
        left_word_s  = snap_a_q;
        right_word_s = snap_b_q;
      end
      default: begin
        left_word_s  = 16'd0;
        right_word_s = 16'd0;
      end
    endcase
  end

  // Stage-0 region decode: at most one branch can match since the regions are disjoint.
  always_comb begin
    src_d  = SRC_NONE;
    idx_d  = 4'd0;
    val_d  = 16'd0;
    addr_d = 11'd0;
    if (!display_on_in) begin
      src_d = SRC_NONE;
    end else if (list_left_s && rows_top_s) begin
      src_d = SRC_VALUE;
      idx_d = list_left_idx_s;
      val_d = {10'd0, top_off_s};
    end else if (list_right_s && rows_top_s) begin
      src_d  = SRC_MEM;
      idx_d  = list_right_idx_s;
      addr_d = {5'd0, top_off_s};
    end else if (list_left_s && rows_bot_s) begin
      src_d = SRC_VALUE;
      idx_d = list_left_idx_s;
      val_d = {5'd0, data_addr_s};
    end else if (list_right_s && rows_bot_s) begin
      src_d  = SRC_MEM;
      idx_d  = list_right_idx_s;
      addr_d = data_addr_s;
    end else if (band_hit_s && (box_left_s || box_right_s)) begin
      if (box_left_s) begin
        src_d = SRC_VALUE;
        idx_d = box_left_idx_s;
        val_d = left_word_s;
      end else if (right_is_mem_s) begin
        src_d  = SRC_MEM;
        idx_d  = box_right_idx_s;
        addr_d = right_addr_s;
      end else begin
        src_d = SRC_VALUE;
        idx_d = box_right_idx_s;
        val_d = right_word_s;
      end
    end else if (z_box_s) begin
      src_d = SRC_VALUE;
      idx_d = 4'd0;
      val_d = {15'd0, snap_z_q};
    end else begin
      src_d = SRC_NONE;
    end
  end

  // Frame snapshot: capture one cycle after the falling v_sync edge has been sampled.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      vs_q       <= 1'b1;
      vs_prev_q  <= 1'b1;
      snap_pc_q  <= 16'd0;
      snap_ir_q  <= 16'd0;
      snap_acc_q <= 16'd0;
      snap_da_q  <= 16'd0;
      snap_a_q   <= 16'd0;
      snap_b_q   <= 16'd0;
      snap_z_q   <= 1'b0;
    end else begin
      vs_q      <= v_sync_in;
      vs_prev_q <= vs_q;
      if (vs_prev_q && !vs_q) begin
        snap_pc_q  <= pc_in;
        snap_ir_q  <= ir_in;
        snap_acc_q <= acc_in;
        snap_da_q  <= data_address_in;
        snap_a_q   <= alu_a_in;
        snap_b_q   <= alu_b_in;
        snap_z_q   <= status_z_in;
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      src1_q  <= SRC_NONE;
      idx1_q  <= 4'd0;
      val1_q  <= 16'd0;
      addr1_q <= 11'd0;
      x1_q    <= 10'd0;
      y1_q    <= 10'd0;
      de1_q   <= 1'b0;
    end else begin
      src1_q  <= src_d;
      idx1_q  <= idx_d;
      val1_q  <= val_d;
      addr1_q <= addr_d;
      x1_q    <= pixel_x_in;
      y1_q    <= pixel_y_in;
      de1_q   <= display_on_in;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      src2_q <= SRC_NONE;
      idx2_q <= 4'd0;
      val2_q <= 16'd0;
      x2_q   <= 10'd0;
      y2_q   <= 10'd0;
      de2_q  <= 1'b0;
    end else begin
      src2_q <= src1_q;
      idx2_q <= idx1_q;
      val2_q <= val1_q;
      x2_q   <= x1_q;
      y2_q   <= y1_q;
      de2_q  <= de1_q;
    end
  end

  // Memory data is valid in stage 2, so the bit is picked here and registered next.
  always_comb begin
    bit_s = 1'b0;
    case (src2_q)
      SRC_MEM:   bit_s = mem_bus.mem_data_in[idx2_q];
      SRC_VALUE: bit_s = val2_q[idx2_q];
      default:   bit_s = 1'b0;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      bit3_q <= 1'b0;
      x3_q   <= 10'd0;
      y3_q   <= 10'd0;
      de3_q  <= 1'b0;
    end else begin
      bit3_q <= bit_s;
      x3_q   <= x2_q;
      y3_q   <= y2_q;
      de3_q  <= de2_q;
    end
  end

  assign mem_bus.mem_address_out = addr1_q;
  assign bit_value_out           = bit3_q;
  assign pixel_x_out             = x3_q;
  assign pixel_y_out             = y3_q;
  assign display_on_out          = de3_q;

endmodule
